// File: rtl/cam_axis_out.sv
// cam_axis_out: read stage behind the camera line buffer.
// Walks the buffer one pixel per clock, collects the read data after RD_LAT
// cycles and streams it out as AXI4-Stream RGB565 video. TUSER flags the first
// pixel of a frame and TLAST the last pixel of each line. A small prefetch FIFO
// rides out TREADY backpressure without ever overflowing.
module cam_axis_out #(
    parameter int H_PIX   = 640,
    parameter int V_LINES = 480,
    parameter int RD_LAT  = 1,
    parameter int FIFO_D  = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        VsyncEdge,
    input  logic        HsyncEdge,
    input  logic [15:0] bufRGB,
    output logic [9:0]  AxiPixCount,
    output logic [8:0]  AxiLineCount,
    output logic [15:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic        M_AXIS_TUSER,
    output logic        M_AXIS_TLAST,
    output logic        FrameDone,
    output logic        Overrun,
    output logic        Busy
);

    localparam int AW = $clog2(FIFO_D);
    localparam int CW = AW + 1;
    localparam logic [9:0]  LAST_PIX  = 10'(H_PIX - 1);
    localparam logic [8:0]  LAST_LINE = 9'(V_LINES - 1);
    localparam logic [CW:0] DEPTH     = (CW + 1)'(FIFO_D);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_LINE,
        S_READ,
        S_DRAIN
    } state_t;

    // Control state and read address
    state_t       r_state;
    logic [9:0]   r_pix;
    logic [8:0]   r_line;
    logic         r_sofPend;
    logic         r_restart;
    logic         r_overrun;
    logic         r_frameDone;

    // Read pipe: issue flag plus the TUSER/TLAST tags of the issued pixel
    logic [RD_LAT-1:0] r_pipeVld;
    logic [RD_LAT-1:0] r_pipeUser;
    logic [RD_LAT-1:0] r_pipeLast;
    logic [CW-1:0]     r_inflight;

    // Prefetch FIFO, entries are {tuser, tlast, tdata}
    logic [17:0]   r_mem [FIFO_D];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    logic        w_room;
    logic        w_issue;
    logic        w_issueUser;
    logic        w_issueLast;
    logic        w_push;
    logic [17:0] w_pushWord;
    logic [17:0] w_head;
    logic        w_valid;
    logic        w_pop;
    logic        w_lastPop;
    logic        w_userPop;

    // Reads are only issued while every outstanding read is guaranteed a FIFO slot
    assign w_room      = ({1'b0, r_count} + {1'b0, r_inflight}) < DEPTH;
    assign w_issue     = (r_state == S_READ) && w_room;
    assign w_issueUser = r_sofPend && (r_pix == 10'd0);
    assign w_issueLast = (r_pix == LAST_PIX);

    assign w_push     = r_pipeVld[RD_LAT-1];
    assign w_pushWord = {r_pipeUser[RD_LAT-1], r_pipeLast[RD_LAT-1], bufRGB};

    assign w_head    = r_mem[r_rdPtr];
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && M_AXIS_TREADY;
    assign w_lastPop = w_pop && w_head[16];
    assign w_userPop = w_pop && w_head[17];

    // Frame/line sequencing: wait for sync pulses, walk the pixels, then drain
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_pix       <= '0;
            r_line      <= '0;
            r_sofPend   <= 1'b0;
            r_restart   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            if (w_userPop) begin
                r_sofPend <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (VsyncEdge) begin
                        r_line    <= '0;
                        r_sofPend <= 1'b1;
                        r_restart <= 1'b0;
                        if (HsyncEdge) begin
                            r_pix   <= '0;
                            r_state <= S_READ;
                        end else begin
                            r_state <= S_WAIT_LINE;
                        end
                    end
                end
                S_WAIT_LINE: begin
                    if (VsyncEdge) begin
                        r_line    <= '0;
                        r_sofPend <= 1'b1;
                        if (r_line != 9'd0) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    if (HsyncEdge) begin
                        r_pix   <= '0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (VsyncEdge) begin
                        r_restart <= 1'b1;
                        r_overrun <= 1'b1;
                    end
                    if (HsyncEdge) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_issue) begin
                        if (w_issueLast) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_pix <= r_pix + 10'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (HsyncEdge || VsyncEdge) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_lastPop) begin
                        if (r_restart || VsyncEdge) begin
                            r_line    <= '0;
                            r_sofPend <= 1'b1;
                            r_restart <= 1'b0;
                            r_state   <= S_WAIT_LINE;
                        end else if (r_line == LAST_LINE) begin
                            r_frameDone <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_line  <= r_line + 9'd1;
                            r_state <= S_WAIT_LINE;
                        end
                    end else if (VsyncEdge) begin
                        r_restart <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Track issued reads until their data comes back from the line buffer
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_pipeVld  <= '0;
            r_pipeUser <= '0;
            r_pipeLast <= '0;
            r_inflight <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_pipeVld[i]  <= r_pipeVld[i-1];
                r_pipeUser[i] <= r_pipeUser[i-1];
                r_pipeLast[i] <= r_pipeLast[i-1];
            end
            r_pipeVld[0]  <= w_issue;
            r_pipeUser[0] <= w_issueUser;
            r_pipeLast[0] <= w_issueLast;
            r_inflight    <= r_inflight + CW'(w_issue) - CW'(w_push);
        end
    end

    // Prefetch FIFO: returning read data in, stream beats out on handshake
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_D; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= w_pushWord;
                r_wrPtr        <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign AxiPixCount   = r_pix;
    assign AxiLineCount  = r_line;
    assign M_AXIS_TVALID = w_valid;
    assign M_AXIS_TDATA  = w_head[15:0];
    assign M_AXIS_TLAST  = w_head[16];
    assign M_AXIS_TUSER  = w_head[17];
    assign FrameDone     = r_frameDone;
    assign Overrun       = r_overrun;
    assign Busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_cam_axis_out.sv
// tb_cam_axis_out: scoreboard bench for cam_axis_out with an 8x2 frame.
// Expected beats are queued as lines are started; a negedge monitor pops and
// compares every handshaken beat and checks that stalled beats stay put.
module tb_cam_axis_out;

    localparam int H_PIX   = 8;
    localparam int V_LINES = 2;
    localparam int RD_LAT  = 1;
    localparam int FIFO_D  = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        VsyncEdge = 1'b0;
    logic        HsyncEdge = 1'b0;
    logic [15:0] bufRGB = '0;
    logic [9:0]  AxiPixCount;
    logic [8:0]  AxiLineCount;
    logic [15:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY = 1'b1;
    logic        M_AXIS_TUSER;
    logic        M_AXIS_TLAST;
    logic        FrameDone;
    logic        Overrun;
    logic        Busy;

    typedef struct packed {
        logic        user;
        logic        last;
        logic [15:0] data;
    } beat_t;

    beat_t       expQ[$];
    beat_t       popped;
    int          total = 0;
    int          bad = 0;
    int          frameDoneCnt = 0;
    logic        randReady = 1'b0;
    logic        prevStall = 1'b0;
    logic [17:0] prevBeat = '0;

    cam_axis_out #(
        .H_PIX(H_PIX),
        .V_LINES(V_LINES),
        .RD_LAT(RD_LAT),
        .FIFO_D(FIFO_D)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .VsyncEdge(VsyncEdge),
        .HsyncEdge(HsyncEdge),
        .bufRGB(bufRGB),
        .AxiPixCount(AxiPixCount),
        .AxiLineCount(AxiLineCount),
        .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TUSER(M_AXIS_TUSER),
        .M_AXIS_TLAST(M_AXIS_TLAST),
        .FrameDone(FrameDone),
        .Overrun(Overrun),
        .Busy(Busy)
    );

    // Free-running system clock
    always #5 CLK = ~CLK;

    // Line buffer stand-in: one-cycle registered read, data encodes the address
    always @(posedge CLK) begin
        bufRGB <= {AxiLineCount[5:0], AxiPixCount};
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectLine(input int line, input bit sof);
        for (int p = 0; p < H_PIX; p++) begin
            beat_t b;
            b.user = sof && (p == 0);
            b.last = (p == H_PIX - 1);
            b.data = 16'((line % 64) * 1024 + p);
            expQ.push_back(b);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit vs, input bit hs);
        VsyncEdge = vs;
        HsyncEdge = hs;
        @(posedge CLK);
        #1;
        VsyncEdge = 1'b0;
        HsyncEdge = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(posedge CLK);
            #1;
            if (randReady) M_AXIS_TREADY = 1'($urandom_range(0, 1));
            n++;
        end
        checkOutput("drain_left", 32'(expQ.size()), 32'd0);
        M_AXIS_TREADY = 1'b1;
        cycles(3);
    endtask

    task automatic waitPix(input logic [9:0] target, input int budget);
        int n = 0;
        while (AxiPixCount != target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("reach_pix", 32'(AxiPixCount), 32'(target));
    endtask

    // Monitor: compare each handshaken beat and hold stalled beats steady
    always @(negedge CLK) begin
        if (!RST_N) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("held_tvalid", 32'(M_AXIS_TVALID), 32'd1);
                checkOutput("held_beat", 32'({M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA}),
                            32'(prevBeat));
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_beat: got 0x%0h, want no beat",
                             {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA});
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("beat", 32'({M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA}),
                                32'(popped));
                end
            end
            prevStall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prevBeat  = {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA};
            if (FrameDone) frameDoneCnt++;
        end
    end

    // Hard time limit so a stuck design still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        $display("[TB] start");
        RST_N = 1'b0;
        cycles(3);
        @(negedge CLK);
        checkOutput("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("rst_busy", 32'(Busy), 32'd0);
        checkOutput("rst_overrun", 32'(Overrun), 32'd0);
        checkOutput("rst_framedone", 32'(FrameDone), 32'd0);
        checkOutput("rst_pix", 32'(AxiPixCount), 32'd0);
        checkOutput("rst_line", 32'(AxiLineCount), 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cycles(2);

        // Plain frame at full rate
        $display("[TB] frame with TREADY high");
        expectLine(0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t1_busy_wait", 32'(Busy), 32'd1);
        applyStimulus(1'b0, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("t1_lat_early", 32'(M_AXIS_TVALID), 32'd0);
        @(negedge CLK);
        checkOutput("t1_lat_first", 32'(M_AXIS_TVALID), 32'd1);
        waitDrain(100);
        expectLine(1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        waitDrain(100);
        checkOutput("t1_framedone", 32'(frameDoneCnt), 32'd1);
        checkOutput("t1_idle", 32'(Busy), 32'd0);

        // Same frame with random backpressure
        $display("[TB] frame with random TREADY");
        randReady = 1'b1;
        expectLine(0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        waitDrain(300);
        expectLine(1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        waitDrain(300);
        randReady = 1'b0;
        checkOutput("t2_framedone", 32'(frameDoneCnt), 32'd2);

        // Long stall mid-line: reads stop with the FIFO full
        $display("[TB] long stall");
        expectLine(0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        cycles(3);
        M_AXIS_TREADY = 1'b0;
        cycles(20);
        checkOutput("t3_stall_pix", 32'(AxiPixCount), 32'd5);
        checkOutput("t3_stall_valid", 32'(M_AXIS_TVALID), 32'd1);
        M_AXIS_TREADY = 1'b1;
        waitDrain(100);
        expectLine(1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        waitDrain(100);
        checkOutput("t3_framedone", 32'(frameDoneCnt), 32'd3);
        checkOutput("t3_overrun", 32'(Overrun), 32'd0);

        // Extra Hsync while reading: flagged and that camera line is skipped
        $display("[TB] hsync during read");
        expectLine(0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        cycles(2);
        applyStimulus(1'b0, 1'b1);
        cycles(1);
        checkOutput("t4_overrun", 32'(Overrun), 32'd1);
        waitDrain(100);
        expectLine(1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        cycles(2);
        checkOutput("t4_line", 32'(AxiLineCount), 32'd1);
        waitDrain(100);
        checkOutput("t4_framedone", 32'(frameDoneCnt), 32'd4);

        // Vsync mid-line: line finishes, frame restarts without FrameDone
        $display("[TB] vsync during read");
        expectLine(0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        waitPix(10'd3, 20);
        applyStimulus(1'b1, 1'b0);
        waitDrain(100);
        checkOutput("t5_no_framedone", 32'(frameDoneCnt), 32'd4);
        checkOutput("t5_busy", 32'(Busy), 32'd1);
        expectLine(0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        cycles(2);
        checkOutput("t5_line", 32'(AxiLineCount), 32'd0);
        waitDrain(100);
        expectLine(1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        waitDrain(100);
        checkOutput("t5_framedone", 32'(frameDoneCnt), 32'd5);

        // Reset with beats waiting in the FIFO
        $display("[TB] reset mid-line");
        expectLine(0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        cycles(1);
        M_AXIS_TREADY = 1'b0;
        cycles(5);
        @(negedge CLK);
        checkOutput("t6_valid_before", 32'(M_AXIS_TVALID), 32'd1);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        checkOutput("t6_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("t6_busy", 32'(Busy), 32'd0);
        checkOutput("t6_overrun", 32'(Overrun), 32'd0);
        expQ.delete();
        M_AXIS_TREADY = 1'b1;
        cycles(2);

        // Clean frame after the reset
        $display("[TB] frame after reset");
        expectLine(0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        waitDrain(100);
        expectLine(1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        waitDrain(100);
        checkOutput("t7_framedone", 32'(frameDoneCnt), 32'd6);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
